// File: rtl/keypad_scan_debounce_pkg.sv
// Shared definitions for the keypad scanner: scan FSM states and the key
// index formula (column-major: idx = c*ROWS + r), also used by keyboard_map.
package keypad_scan_debounce_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_COMPARE = 2'd2
  } scan_state_e;

  localparam int DEF_ROWS = 4;
  localparam int DEF_COLS = 4;

  function automatic int key_index(input int c, input int r, input int rows);
    return c * rows + r;
  endfunction

endpackage

// File: rtl/keypad_scan_debounce_scan_tick_gen.sv
// scan_tick_gen: free-running divider producing a one-cycle tick every DIV
// clkin cycles (DIV=1 -> tick held high).
//   clkin  in  system clock
//   rst    in  async active-low reset
//   tick   out scan enable
module scan_tick_gen #(
  parameter int DIV = 50000
) (
  input  logic clkin,
  input  logic rst,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] div_cnt;

  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst)      div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

endmodule

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: matrix keypad scanner with whole-frame debounce and
// press/release events.
//   clkin        in   system clock
//   rst          in   async active-low reset
//   row          in   row lines, 0 = closed on the driven column
//   col          out  column drive, one bit low while scanning, else all 1
//   keys         out  debounced map, 1 = pressed, bit = c*ROWS + r
//   key_valid    out  1-cycle pulse: at least one key newly pressed
//   key_code     out  lowest newly pressed index, held until next press
//   key_release  out  1-cycle pulse: at least one key newly released
//   multi        out  more than one key held
module keypad_scan_debounce
  import keypad_scan_debounce_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int DIV      = 50000,
  parameter int SETTLE   = 8,
  parameter int DEBOUNCE = 3,
  parameter int KEYW     = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic                   clkin,
  input  logic                   rst,
  input  logic [ROWS-1:0]        row,
  output logic [COLS-1:0]        col,
  output logic [ROWS*COLS-1:0]   keys,
  output logic                   key_valid,
  output logic [KEYW-1:0]        key_code,
  output logic                   key_release,
  output logic                   multi
);
  localparam int NK = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int DW = $clog2(DEBOUNCE + 1);

  function automatic logic [KEYW-1:0] lowest_idx(input logic [NK-1:0] v);
    lowest_idx = '0;
    for (int i = NK - 1; i >= 0; i--)
      if (v[i]) lowest_idx = KEYW'(i);
  endfunction

  function automatic logic many_set(input logic [NK-1:0] v);
    logic seen;
    seen     = 1'b0;
    many_set = 1'b0;
    for (int i = 0; i < NK; i++)
      if (v[i]) begin
        if (seen) many_set = 1'b1;
        seen = 1'b1;
      end
  endfunction

  scan_state_e   state, state_n;
  logic          tick;
  logic [CW-1:0] col_idx;
  logic [SW-1:0] settle_cnt;
  logic [NK-1:0] frame, last_frame;
  logic [DW-1:0] stable_cnt, stable_n;
  logic [NK-1:0] new_keys, gone_keys;
  logic          sample, last_col, upd;

  scan_tick_gen #(.DIV(DIV)) u_tick (
    .clkin (clkin),
    .rst   (rst),
    .tick  (tick)
  );

  assign multi = many_set(keys);

  always_comb begin
    state_n   = state;
    sample    = (state == S_DRIVE) && (settle_cnt == SW'(SETTLE - 1));
    last_col  = (col_idx == CW'(COLS - 1));
    // A changed frame restarts stability at 1; otherwise count up and saturate.
    stable_n  = (frame != last_frame)        ? DW'(1) :
                (stable_cnt == DW'(DEBOUNCE)) ? stable_cnt : stable_cnt + DW'(1);
    upd       = (stable_n == DW'(DEBOUNCE)) && (frame != keys);
    new_keys  = frame & ~keys;
    gone_keys = keys & ~frame;
    if (tick) begin
      case (state)
        S_IDLE:    state_n = S_DRIVE;
        S_DRIVE:   if (sample && last_col) state_n = S_COMPARE;
        S_COMPARE: state_n = S_IDLE;
        default:   state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      col         <= '1;
      col_idx     <= '0;
      settle_cnt  <= '0;
      frame       <= '0;
      last_frame  <= '0;
      stable_cnt  <= '0;
      keys        <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      // Pulses are cleared every clkin so they stay one cycle wide for any DIV.
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      if (tick) begin
        case (state)
          S_IDLE: begin
            col        <= ~COLS'(1);
            col_idx    <= '0;
            settle_cnt <= '0;
          end
          S_DRIVE: begin
            if (sample) begin
              frame[key_index(int'(col_idx), 0, ROWS) +: ROWS] <= ~row;
              settle_cnt <= '0;
              if (!last_col) begin
                col_idx <= col_idx + CW'(1);
                col     <= ~(COLS'(1) << (col_idx + CW'(1)));
              end else begin
                col <= '1;
              end
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          S_COMPARE: begin
            last_frame <= frame;
            stable_cnt <= stable_n;
            if (upd) begin
              keys <= frame;
              if (|new_keys) begin
                key_code  <= lowest_idx(new_keys);
                key_valid <= 1'b1;
              end
              if (|gone_keys) key_release <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
